astar_open_list: RTL and testbench

Sorted open-list buffer for the A* search core. Holds up to `DEPTH` candidate grid nodes keyed by f-cost and always presents the lowest-cost node at its head. `astar_algorithm` pushes expanded neighbours and pops the next node to expand. Insert and pop each complete in one `sync` cycle, with no multi-cycle search.

---
 rtl/astar_open_list.sv | 112 +++++++++++
 tb/tb_astar_open_list.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/astar_open_list.sv
// astar_open_list: sorted open list; the lowest f-cost node always sits in slot 0 and drives pop_*.
// Latency 1 cycle push-to-head; push_ready drops only when full without a same-cycle pop.
// Optional decrease-key on matching node: define ASTAR_OPEN_LIST_DEDUP_EN.
module astar_open_list #(
    parameter int DEPTH  = 16,
    parameter int NODE_W = 8,
    parameter int COST_W = 10
) (
    input  logic                       sync,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [NODE_W-1:0]          push_node,
    input  logic [COST_W-1:0]          push_cost,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [NODE_W-1:0]          pop_node,
    output logic [COST_W-1:0]          pop_cost,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic              vld;
        logic [NODE_W-1:0] node;
        logic [COST_W-1:0] cost;
    } slot_t;

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    // cur/base carry one extra empty slot so shifts never index past the array
    slot_t cur  [DEPTH+1];
    slot_t base [DEPTH+1];
    slot_t rem  [DEPTH];
    slot_t new_ent, prev_ent;
    logic  do_pop, do_ins, do_rm, gt, prev_gt;
`ifdef ASTAR_OPEN_LIST_DEDUP_EN
    logic              hit_cur, hit, seen;
    logic [COST_W-1:0] hit_cost;
`endif

    always_comb begin
        do_pop     = (count_q != '0) && pop_ready;
        push_ready = (count_q != CNT_W'(DEPTH)) || do_pop;
        new_ent    = '{vld: 1'b1, node: push_node, cost: push_cost};
        do_rm      = 1'b0;
        for (int i = 0; i < DEPTH; i++) cur[i] = slot_q[i];
        cur[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) base[i] = do_pop ? cur[i+1] : cur[i];
        base[DEPTH] = '0;
`ifdef ASTAR_OPEN_LIST_DEDUP_EN
        hit_cur = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_q[i].vld && slot_q[i].node == push_node) hit_cur = 1'b1;
        push_ready = push_ready || hit_cur;
        // match against the post-pop list so a popped duplicate becomes a plain insert
        hit      = 1'b0;
        hit_cost = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && base[i].vld && base[i].node == push_node) begin
                hit      = 1'b1;
                hit_cost = base[i].cost;
            end
        end
        do_ins = push_valid && push_ready && (!hit || push_cost < hit_cost);
        do_rm  = do_ins && hit;
        seen   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_rm && base[i].vld && base[i].node == push_node) seen = 1'b1;
            rem[i] = seen ? base[i+1] : base[i];
        end
`else
        do_ins = push_valid && push_ready;
        for (int i = 0; i < DEPTH; i++) rem[i] = base[i];
`endif
        // gt is monotonic over a sorted list: first true slot takes the new entry
        gt       = 1'b0;
        prev_gt  = 1'b0;
        prev_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            gt        = !rem[i].vld || (push_cost < rem[i].cost);
            slot_d[i] = (do_ins && gt) ? (prev_gt ? prev_ent : new_ent) : rem[i];
            prev_gt   = gt;
            prev_ent  = rem[i];
        end
        count_d = count_q + CNT_W'(do_ins) - CNT_W'(do_pop) - CNT_W'(do_rm);
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge sync or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            count_q <= count_d;
        end
    end

    assign pop_valid = (count_q != '0);
    assign pop_node  = slot_q[0].node;
    assign pop_cost  = slot_q[0].cost;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
endmodule

// File: tb/tb_astar_open_list.sv
// Bench for astar_open_list: directed scenarios plus randomized traffic against a queue model.
module tb_astar_open_list;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             sync = 1'b0;
    logic             reset, clear, push_valid, push_ready, pop_valid, pop_ready, full;
    logic [7:0]       push_node, pop_node;
    logic [9:0]       push_cost, pop_cost;
    logic [CNT_W-1:0] count;

    astar_open_list #(.DEPTH(DEPTH), .NODE_W(8), .COST_W(10)) dut (
        .sync(sync), .reset(reset), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_node(push_node), .push_cost(push_cost),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_node(pop_node), .pop_cost(pop_cost),
        .count(count), .full(full)
    );

    always #5 sync = ~sync;

    typedef struct {
        logic [7:0] node;
        logic [9:0] cost;
    } ent_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic bit model_ready(input bit pr, input logic [7:0] n);
        bit r;
        r = (mq.size() != DEPTH) || (pr && mq.size() != 0);
`ifdef ASTAR_OPEN_LIST_DEDUP_EN
        foreach (mq[i]) if (mq[i].node == n) r = 1'b1;
`endif
        return r;
    endfunction

    task automatic model_step(input bit clr, input bit pv, input logic [7:0] n,
                              input logic [9:0] c, input bit pr);
        bit   rdy, ins;
        int   idx;
        ent_t e;
        if (clr) begin
            mq.delete();
            return;
        end
        rdy = model_ready(pr, n);
        if (pr && mq.size() != 0) void'(mq.pop_front());
        if (pv && rdy) begin
            ins = 1'b1;
`ifdef ASTAR_OPEN_LIST_DEDUP_EN
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].node == n) begin
                    if (c < mq[i].cost) mq.delete(i);
                    else ins = 1'b0;
                    break;
                end
            end
`endif
            if (ins) begin
                idx = mq.size();
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].cost > c) begin
                        idx = i;
                        break;
                    end
                end
                e.node = n;
                e.cost = c;
                mq.insert(idx, e);
            end
        end
    endtask

    task automatic set_in(input bit clr, input bit pv, input logic [7:0] n,
                          input logic [9:0] c, input bit pr);
        clear      = clr;
        push_valid = pv;
        push_node  = n;
        push_cost  = c;
        pop_ready  = pr;
    endtask

    task automatic tick();
        model_step(clear, push_valid, push_node, push_cost, pop_ready);
        @(posedge sync);
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 8'h00, 10'd0, 0);
        reset = 1'b0;
        repeat (2) @(posedge sync);
        @(negedge sync);
        reset = 1'b1;
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
        checks++; if (pop_cost !== 10'd0) begin errors++; $display("FAIL reset_pop_cost: got %0d expected 0", pop_cost); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    endtask

    task automatic test_sorted_insert();
        logic [7:0] in_n  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [9:0] in_c  [4] = '{10'd40, 10'd10, 10'd25, 10'd10};
        logic [7:0] exp_n [4] = '{8'h02, 8'h04, 8'h03, 8'h01};
        logic [9:0] exp_c [4] = '{10'd10, 10'd10, 10'd25, 10'd40};
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1, in_n[k], in_c[k], 0);
            tick();
        end
        checks++; if (count !== CNT_W'(4)) begin errors++; $display("FAIL sorted_count: got %0d expected 4", count); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pop_valid !== 1'b1 || pop_node !== exp_n[k] || pop_cost !== exp_c[k]) begin
                errors++;
                $display("FAIL sorted_pop%0d: got v=%b (%h,%0d) expected v=1 (%h,%0d)",
                         k, pop_valid, pop_node, pop_cost, exp_n[k], exp_c[k]);
            end
            set_in(0, 0, 8'h00, 10'd0, 1);
            tick();
            checks++;
            if (count !== CNT_W'(3 - k)) begin
                errors++; $display("FAIL sorted_count_after_pop%0d: got %0d expected %0d", k, count, 3 - k);
            end
        end
    endtask

    task automatic test_full_boundary();
        for (int k = 0; k < DEPTH; k++) begin
            set_in(0, 1, 8'(k), 10'($urandom_range(0, 1023)), 0);
            tick();
        end
        checks++; if (count !== CNT_W'(DEPTH) || full !== 1'b1) begin errors++; $display("FAIL full_fill: got count=%0d full=%b expected count=16 full=1", count, full); end
        set_in(0, 1, 8'hAA, 10'd5, 0);
        #1;
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready_no_pop: got %b expected 0", push_ready); end
        tick();
        checks++; if (count !== CNT_W'(DEPTH)) begin errors++; $display("FAIL full_reject: got count=%0d expected 16", count); end
        set_in(0, 1, 8'hAA, 10'd5, 1);
        #1;
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL full_ready_with_pop: got %b expected 1", push_ready); end
        tick();
        checks++;
        if (count !== CNT_W'(DEPTH) || full !== 1'b1 || pop_node !== mq[0].node || pop_cost !== mq[0].cost) begin
            errors++;
            $display("FAIL full_push_pop: got count=%0d full=%b head=(%h,%0d) expected count=16 full=1 head=(%h,%0d)",
                     count, full, pop_node, pop_cost, mq[0].node, mq[0].cost);
        end
    endtask

    task automatic test_empty_boundary();
        set_in(1, 0, 8'h00, 10'd0, 0);
        tick();
        checks++; if (count !== '0) begin errors++; $display("FAIL empty_clear: got %0d expected 0", count); end
        set_in(0, 1, 8'h33, 10'd77, 1);
        #1;
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b expected 1", push_ready); end
        tick();
        checks++;
        if (count !== CNT_W'(1) || pop_valid !== 1'b1 || pop_node !== 8'h33 || pop_cost !== 10'd77) begin
            errors++;
            $display("FAIL empty_push_pop: got count=%0d v=%b (%h,%0d) expected count=1 v=1 (33,77)",
                     count, pop_valid, pop_node, pop_cost);
        end
    endtask

    task automatic test_clear_reset();
        set_in(1, 0, 8'h00, 10'd0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1, 8'(8'h40 + k), 10'($urandom_range(0, 63)), 0);
            tick();
        end
        checks++; if (count !== CNT_W'(5)) begin errors++; $display("FAIL clear_fill: got %0d expected 5", count); end
        set_in(1, 1, 8'h55, 10'd3, 1);
        tick();
        checks++; if (count !== '0 || pop_valid !== 1'b0) begin errors++; $display("FAIL clear_with_push: got count=%0d v=%b expected 0 0", count, pop_valid); end
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 8'(8'h60 + k), 10'(100 - k), 0);
            tick();
        end
        checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL refill: got %0d expected 3", count); end
        set_in(0, 0, 8'h00, 10'd0, 0);
        @(negedge sync);
        #2;
        reset = 1'b0;
        mq.delete();
        #1;
        checks++;
        if (count !== '0 || pop_valid !== 1'b0 || pop_node !== 8'h00 || pop_cost !== 10'd0 || full !== 1'b0 || push_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got count=%0d v=%b (%h,%0d) full=%b rdy=%b expected all zero, rdy=1",
                     count, pop_valid, pop_node, pop_cost, full, push_ready);
        end
        reset = 1'b1;
    endtask

    task automatic test_dedup();
        int exp_cnt1, exp_cnt2;
`ifdef ASTAR_OPEN_LIST_DEDUP_EN
        exp_cnt1 = 1; exp_cnt2 = 1;
`else
        exp_cnt1 = 2; exp_cnt2 = 3;
`endif
        set_in(1, 0, 8'h00, 10'd0, 0);
        tick();
        set_in(0, 1, 8'h21, 10'd50, 0);
        tick();
        set_in(0, 1, 8'h21, 10'd30, 0);
        tick();
        checks++;
        if (count !== CNT_W'(exp_cnt1) || pop_node !== 8'h21 || pop_cost !== 10'd30) begin
            errors++;
            $display("FAIL dedup_lower: got count=%0d (%h,%0d) expected count=%0d (21,30)", count, pop_node, pop_cost, exp_cnt1);
        end
        set_in(0, 1, 8'h21, 10'd60, 0);
        tick();
        checks++;
        if (count !== CNT_W'(exp_cnt2) || pop_node !== 8'h21 || pop_cost !== 10'd30) begin
            errors++;
            $display("FAIL dedup_higher: got count=%0d (%h,%0d) expected count=%0d (21,30)", count, pop_node, pop_cost, exp_cnt2);
        end
    endtask

    task automatic test_random();
        bit         pv, pr, clr, exp_r;
        int         pp, pq;
        logic [7:0] n;
        logic [9:0] c;
        for (int cyc = 0; cyc < 800; cyc++) begin
            pp  = ((cyc / 100) % 2 == 0) ? 80 : 30;
            pq  = ((cyc / 100) % 2 == 0) ? 25 : 70;
            pv  = ($urandom_range(0, 99) < pp);
            pr  = ($urandom_range(0, 99) < pq);
            clr = ($urandom_range(0, 149) == 0);
            n   = 8'($urandom_range(0, 23));
            c   = 10'($urandom_range(0, 15));
            set_in(clr, pv, n, c, pr);
            #1;
            exp_r = model_ready(pr, n);
            checks++; if (push_ready !== exp_r) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", cyc, push_ready, exp_r); end
            tick();
            checks++;
            if (count !== CNT_W'(mq.size()) || pop_valid !== (mq.size() != 0) || full !== (mq.size() == DEPTH)) begin
                errors++;
                $display("FAIL rand_state@%0d: got count=%0d v=%b full=%b expected count=%0d",
                         cyc, count, pop_valid, full, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (pop_node !== mq[0].node || pop_cost !== mq[0].cost) begin
                    errors++;
                    $display("FAIL rand_head@%0d: got (%h,%0d) expected (%h,%0d)", cyc, pop_node, pop_cost, mq[0].node, mq[0].cost);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 8'h00, 10'd0, 0);
        test_reset();
        test_sorted_insert();
        test_full_boundary();
        test_empty_boundary();
        test_clear_reset();
        test_dedup();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
